// File: rtl/data_sram_bridge.sv
// Posted-write SRAM-to-split-handshake data bus bridge: writes buffered in a FIFO, reads stall until data returns.
// Latency: 0-cycle write accept when not full, >=3-cycle read stall; backpressure via stall (FIFO full or read in flight).

module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

module data_sram_bridge #(
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [1:0]  size;
  } wb_entry_t;

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RDATA, RDONE} state_t;

  state_t      state;
  wb_entry_t   new_entry;
  wb_entry_t   head;
  logic        wb_full;
  logic        wb_empty;
  logic        rd_pend;
  logic        wr_pend;
  logic        push;
  logic        pop;
  logic [31:0] rdata_q;

  // Irregular strobe patterns fall back to a word-sized write.
  function automatic logic [1:0] wen_size(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd2;
    endcase
  endfunction

  assign rd_pend = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr_pend = data_sram_en && (data_sram_wen != 4'b0000);
  assign push    = wr_pend && !wb_full;
  assign pop     = (state == WDATA) && data_data_ok;
  assign stall   = (rd_pend && (state != RDONE)) || (wr_pend && wb_full);

  assign new_entry = '{addr: data_sram_addr, wstrb: data_sram_wen,
                       wdata: data_sram_wdata, size: wen_size(data_sram_wen)};

  wb_fifo #(.W($bits(wb_entry_t)), .DEPTH(WB_DEPTH)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (new_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_wstrb <= 4'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // Reads only go out once every buffered store has drained.
          if (rd_pend && wb_empty) begin
            state      <= RADDR;
            data_req   <= 1'b1;
            data_wr    <= 1'b0;
            data_size  <= 2'd2;
            data_wstrb <= 4'd0;
            data_addr  <= {data_sram_addr[31:2], 2'b00};
          end else if (!wb_empty) begin
            state      <= WADDR;
            data_req   <= 1'b1;
            data_wr    <= 1'b1;
            data_size  <= head.size;
            data_wstrb <= head.wstrb;
            data_addr  <= head.addr;
            data_wdata <= head.wdata;
          end
        end
        WADDR: if (data_addr_ok) begin
          state    <= WDATA;
          data_req <= 1'b0;
        end
        WDATA: if (data_data_ok) state <= IDLE;
        RADDR: if (data_addr_ok) begin
          state    <= RDATA;
          data_req <= 1'b0;
        end
        RDATA: if (data_data_ok) begin
          rdata_q <= data_rdata;
          state   <= RDONE;
        end
        RDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_sram_rdata = rdata_q;
endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: expected bus transactions and load words are queued at stimulus time.
module tb_data_sram_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  data_sram_bridge #(.WB_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stall(stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_rd[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int aok_delay = 0;
  int dok_delay = 0;
  bit hold_addr = 1'b0;
  logic [31:0] rd_word = 32'h0;
  int acnt = 0;
  int dcnt = 0;
  bit dpend = 1'b0;
  bit dpend_wr = 1'b0;
  int last_dok_cyc = -1;
  int wdok_cnt = 0;
  int rd_hs_wdok = 0;
  logic [31:0] ref_addr = 32'h0;
  logic [1:0]  ref_size = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] w);
    case (w)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd2;
    endcase
  endfunction

  initial forever @(posedge clk) cyc++;

  // Bus slave: addr_ok after aok_delay waiting cycles, data_ok dok_delay cycles after the handshake.
  initial begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (dpend) begin
        chk("req_while_busy", 32'(data_req), 32'd0);
        if (dcnt == 0) begin
          data_data_ok = 1'b1;
          data_rdata   = dpend_wr ? 32'h0 : rd_word;
          dpend        = 1'b0;
          if (dpend_wr) begin
            last_dok_cyc = cyc;
            wdok_cnt++;
          end
        end else dcnt--;
      end else if (data_req && !hold_addr) begin
        if (acnt >= aok_delay) begin
          if (aok_delay > 0) begin
            chk("bp_addr_stable", data_addr, ref_addr);
            chk("bp_size_stable", 32'(data_size), 32'(ref_size));
          end
          data_addr_ok = 1'b1;
          acnt     = 0;
          dpend    = 1'b1;
          dcnt     = dok_delay;
          dpend_wr = data_wr;
          if (!data_wr) rd_hs_wdok = wdok_cnt;
          chk("txn_avail", 32'(exp_txn.size() != 0), 32'd1);
          if (exp_txn.size() != 0) begin
            txn_t e;
            e = exp_txn.pop_front();
            chk("bus_wr", 32'(data_wr), 32'(e.wr));
            chk("bus_size", 32'(data_size), 32'(e.size));
            chk("bus_wstrb", 32'(data_wstrb), 32'(e.wstrb));
            chk("bus_addr", data_addr, e.addr);
            if (e.wr) chk("bus_wdata", data_wdata, e.wdata);
          end
        end else begin
          if (acnt == 0) begin
            ref_addr = data_addr;
            ref_size = data_size;
          end else begin
            chk("bp_addr_stable", data_addr, ref_addr);
            chk("bp_size_stable", 32'(data_size), 32'(ref_size));
          end
          acnt++;
        end
      end
    end
  end

  task automatic push_wr(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_txn.push_back('{wr: 1'b1, size: exp_size(w), wstrb: w, addr: a, wdata: d});
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] word);
    exp_txn.push_back('{wr: 1'b0, size: 2'd2, wstrb: 4'd0, addr: {a[31:2], 2'b00}, wdata: 32'h0});
    exp_rd.push_back(word);
  endtask

  // Holds the request until stall drops; returns stall cycles and the accept cycle.
  task automatic issue(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       output int sc, output int acc);
    data_sram_en    = 1'b1;
    data_sram_wen   = w;
    data_sram_addr  = a;
    data_sram_wdata = d;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      if (sc > 300) begin
        chk("stall_timeout", 32'(sc), 32'd0);
        break;
      end
    end
    acc = cyc;
    if (w == 4'b0000) begin
      chk("rd_avail", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) chk("load_rdata", data_sram_rdata, exp_rd.pop_front());
    end
    @(posedge clk);
    #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'b0000;
  endtask

  task automatic wait_quiet();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_txn.size() != 0 || dpend || data_req) && t < 500);
    if (t >= 500) chk("quiet_timeout", 32'(t), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [3:0]  tbl_wen  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1111, 4'b0101};
  logic [31:0] tbl_addr [5] = '{32'h1000, 32'h1001, 32'h1002, 32'h1004, 32'h1008};
  logic [31:0] tbl_dat  [5] = '{32'h0000_0012, 32'h0000_3400, 32'h0056_0000, 32'h89AB_CDEF, 32'h0077_0066};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int sc, acc, base, t;
    rst = 1'b0;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    #12;
    chk("reset_req", 32'(data_req), 32'd0);
    chk("reset_rdata", data_sram_rdata, 32'd0);
    chk("reset_stall_rd_pending", 32'(stall), 32'd1);
    data_sram_en = 1'b0;
    #1;
    chk("reset_stall_idle", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    push_wr(4'b1000, 32'h103, 32'hAB00_0000);
    issue(4'b1000, 32'h103, 32'hAB00_0000, sc, acc);
    chk("byte_store_stall", 32'(sc), 32'd0);
    wait_quiet();

    for (int i = 0; i < 5; i++) begin
      push_wr(tbl_wen[i], tbl_addr[i], tbl_dat[i]);
      issue(tbl_wen[i], tbl_addr[i], tbl_dat[i], sc, acc);
      chk("size_tbl_stall", 32'(sc), 32'd0);
      wait_quiet();
    end

    rd_word = 32'h1122_3344;
    push_rd(32'h206, rd_word);
    issue(4'b0000, 32'h206, 32'h0, sc, acc);
    chk("read_stall_cycles", 32'(sc), 32'd3);
    wait_quiet();

    base = wdok_cnt;
    push_wr(4'b0011, 32'h10, 32'h0000_BEEF);
    push_wr(4'b1100, 32'h10, 32'hCAFE_0000);
    rd_word = 32'h5A5A_1234;
    push_rd(32'h10, rd_word);
    issue(4'b0011, 32'h10, 32'h0000_BEEF, sc, acc);
    chk("order_w1_stall", 32'(sc), 32'd0);
    issue(4'b1100, 32'h10, 32'hCAFE_0000, sc, acc);
    chk("order_w2_stall", 32'(sc), 32'd0);
    issue(4'b0000, 32'h10, 32'h0, sc, acc);
    chk("order_rd_stall_min", 32'(sc >= 6), 32'd1);
    chk("order_rd_after_wr_done", 32'(rd_hs_wdok - base), 32'd2);
    wait_quiet();

    hold_addr = 1'b1;
    push_wr(4'b1111, 32'h20, 32'h1111_1111);
    push_wr(4'b0001, 32'h24, 32'h0000_00BB);
    push_wr(4'b1100, 32'h28, 32'hCCDD_0000);
    issue(4'b1111, 32'h20, 32'h1111_1111, sc, acc);
    chk("full_a_stall", 32'(sc), 32'd0);
    issue(4'b0001, 32'h24, 32'h0000_00BB, sc, acc);
    chk("full_b_stall", 32'(sc), 32'd0);
    fork
      issue(4'b1100, 32'h28, 32'hCCDD_0000, sc, acc);
      begin
        repeat (5) @(negedge clk);
        hold_addr = 1'b0;
      end
    join
    chk("full_c_stalled", 32'(sc > 0), 32'd1);
    chk("full_push_after_pop", 32'(acc), 32'(last_dok_cyc + 1));
    wait_quiet();

    aok_delay = 4;
    rd_word = 32'hDEAD_BEEF;
    push_rd(32'h3000_0008, rd_word);
    issue(4'b0000, 32'h3000_0008, 32'h0, sc, acc);
    chk("bp_read_stall_cycles", 32'(sc), 32'd7);
    aok_delay = 0;
    wait_quiet();

    dok_delay = 10;
    rd_word = 32'h0000_0077;
    exp_txn.push_back('{wr: 1'b0, size: 2'd2, wstrb: 4'd0, addr: 32'h400, wdata: 32'h0});
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h400;
    t = 0;
    while (!dpend && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_rdata", 32'(dpend), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(data_req), 32'd0);
    chk("rst_mid_stall_eq", 32'(stall), 32'd1);
    chk("rst_mid_rdata", data_sram_rdata, 32'd0);
    data_sram_en = 1'b0;
    #1;
    chk("rst_mid_stall_idle", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dok_delay = 0;
    rd_word = 32'h9999_9999;
    t = 0;
    while (dpend && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("stray_ok_req", 32'(data_req), 32'd0);
    chk("stray_ok_rdata", data_sram_rdata, 32'd0);
    @(posedge clk);
    #1;
    rd_word = 32'h55AA_55AA;
    push_rd(32'h500, rd_word);
    issue(4'b0000, 32'h500, 32'h0, sc, acc);
    chk("post_rst_read_stall", 32'(sc), 32'd3);
    wait_quiet();

    chk("txn_left", 32'(exp_txn.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Sits directly downstream of the data-memory stage. Takes its single-cycle SRAM-style request (`data_sram_en`, `data_sram_wen`, `data_sram_addr`, `data_sram_wdata`) and converts it to the split-handshake data bus (`req`/`addr_ok`/`data_ok`). Stores are posted into a small write buffer. Loads stall the pipeline until their data returns. Loads are ordered behind all buffered stores, so no forwarding is needed.

## Interface
- `WB_DEPTH`, 2: write-buffer entries; must be a power of two and at least 1.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `data_sram_en` in 1: request valid. Held stable while `stall`=1.
- `data_sram_wen` in 4: byte strobes. Zero means read.
- `data_sram_addr` in 32: byte address.
- `data_sram_wdata` in 32: store data, lane-aligned.
- `data_sram_rdata` out 32: load word. Valid while `rd_done`=1.
- `stall` out 1: upstream must hold its request.
- `data_req` out 1: bus request.
- `data_wr` out 1: 1 = write.
- `data_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_wstrb` out 4: byte strobes. 0 for reads.
- `data_addr` out 32: bus address.
- `data_wdata` out 32: write data.
- `data_addr_ok` in 1: address accepted.
- `data_rdata` in 32: read data.
- `data_data_ok` in 1: transaction complete.

## Operation
- **Bus FSM states:** IDLE, WADDR, WDATA, RADDR, RDATA, RDONE. Outputs are driven from registered state. At most one bus transaction is outstanding.
- **Write buffer:** FIFO of {addr, wstrb, wdata, size}. A push happens when `data_sram_en` && `wen`≠0 && count<`WB_DEPTH`. A full buffer stalls the write; there is no push on the pop cycle.
- **Size from `wen`:**
  - 0001/0010/0100/1000 → 0.
  - 0011/1100 → 1.
  - 1111 → 2.
  - Any other nonzero `wen` is treated as word.
- **Write address:** `data_addr` = entry addr unmodified.
- **IDLE:**
  - If a read is pending (`en` && `wen`==0) and the FIFO is empty → RADDR.
  - Otherwise, if the FIFO is non-empty → WADDR.
  - A pending read with a non-empty FIFO drains the writes first.
- **WADDR:** `data_req`=1, `data_wr`=1, outputs come from the FIFO head. On `addr_ok` → WDATA.
- **WDATA:** `data_req`=0. On `data_ok`, pop the FIFO and go to IDLE.
- **RADDR:**
  - `data_req`=1, `data_wr`=0, `data_size`=2, `data_wstrb`=0.
  - `data_addr` = {addr[31:2], 2'b00}, always a word read.
  - On `addr_ok` → RDATA.
- **RDATA:** on `data_ok`, capture `data_rdata` into the rdata register and go to RDONE.
- **RDONE:** `stall`=0 and the rdata register drives `data_sram_rdata`. Go to IDLE unconditionally; the next cycle's request is a new one.
- **`stall` (combinational):** asserted when either condition holds:
  - A read is pending and the state is not RDONE.
  - A write is pending and the FIFO is full.
- `data_sram_en`=0 never stalls.
- Bus outputs stay stable while `data_req`=1 and `addr_ok`=0.
- `data_sram_addr`/`wdata` are only sampled on a push or on IDLE→RADDR. The read address is latched at IDLE→RADDR.
- A `data_ok` arriving in any state other than WDATA/RDATA is ignored.

## Timing
- **Reset** (`rst`=0, asynchronous):
  - State IDLE, FIFO count 0, pointers 0, rdata register 0.
  - `data_req`=0, `stall` follows its equation, `data_sram_rdata`=0.
  - Any in-flight bus transaction is abandoned.
- **Read with empty FIFO and zero-wait bus** (read first seen at cycle 0):
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: RADDR, `req`=1, `addr_ok`=1.
  - Cycle 2: RDATA, `data_ok`=1.
  - Cycle 3: RDONE, `stall`=0, data valid.
  - Minimum read stall is 3 cycles.
- **Write:** 0 cycles of stall when the FIFO is not full. The bus issues from the cycle after the push at the earliest.
- **Read behind N buffered writes:** each write costs at least 2 cycles (WADDR, WDATA), plus 1 IDLE cycle between transactions.
- The FIFO pointers wrap modulo `WB_DEPTH`. The count is `log2(WB_DEPTH)+1` bits.
- A push and a pop in the same cycle leave the count unchanged.

## Test plan
- **Reset mid-read:** put the FSM in RDATA, then pulse `rst` low. `data_req`=0 immediately. After release, IDLE with FIFO empty. A later `data_ok` is ignored.
- **Byte store:** addr 0x103, `wen`=1000, wdata 0xAB000000. Bus shows `wr`=1, size 0, `wstrb`=1000, addr 0x103. `stall` is never asserted.
- **Read, zero-wait bus:** read at 0x206 with bus returning 0x11223344. `stall` is high for exactly 3 cycles. `data_addr`=0x204, and `data_sram_rdata`=0x11223344 in RDONE.
- **Ordering:** two half stores to 0x10 (`wen` 0011, then 1100), then a read of 0x10. Bus sees WADDR, WADDR, RADDR, in that order. No read `req` is issued before the second write's `data_ok`.
- **Full buffer** (`WB_DEPTH`=2, `addr_ok` held 0):
  - The third store stalls until the first `data_ok`.
  - It is pushed the cycle after that pop.
  - FIFO contents and order are preserved across the pointer wrap.
- **Back-pressure:** `addr_ok` delayed 4 cycles on a read. `data_addr`/`size` are stable throughout and `stall` stays high. Data is delivered on the cycle after `data_ok`.
